// File: rtl/demux1to2_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux1to2_stream
//  Purpose  : Registered 1-to-2 stream demultiplexer with valid/ready
//             handshake. Each accepted word goes to branch A (sel=1) or
//             branch B (sel=0). Each branch has a one-entry output register
//             and a saturating count of completed transfers.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_data/in_valid/sel/in_ready - upstream stream and routing
//             a_data/a_valid/a_ready         - branch A downstream stream
//             b_data/b_valid/b_ready         - branch B downstream stream
//             cnt_clr             - synchronous clear of both counters
//             a_cnt, b_cnt        - per-branch saturating transfer counts
//  Options  : DEMUX_ALT_EN - when defined, sel is ignored and an internal
//             toggle flop alternates the branch (A first), inverting on
//             every accepted word.
//  Revision : 1.0 - initial release
// ============================================================================
module demux1to2_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic route_a;
  logic free_a;
  logic free_b;
  logic accept;
  logic load_a;
  logic load_b;
  logic a_hs;
  logic b_hs;

`ifdef DEMUX_ALT_EN
  // Round-robin routing: sel is intentionally not used in this build.
  logic toggle;
  logic unused_sel;
  assign unused_sel = sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle <= 1'b1;
    end else if (accept) begin
      toggle <= ~toggle;
    end
  end

  assign route_a = toggle;
`else
  assign route_a = sel;
`endif

  // A slot can take a new word if it is empty or is being drained this cycle,
  // which lets a branch sustain one word per cycle.
  assign free_a = !a_valid || a_ready;
  assign free_b = !b_valid || b_ready;

  // Only the selected branch gates acceptance; in_valid is deliberately absent.
  assign in_ready = !rst && (route_a ? free_a : free_b);

  assign accept = in_valid && in_ready;
  assign load_a = accept && route_a;
  assign load_b = accept && !route_a;
  assign a_hs   = a_valid && a_ready;
  assign b_hs   = b_valid && b_ready;

  // Branch A output register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else if (load_a) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
    end else if (a_ready) begin
      a_valid <= 1'b0;
    end
  end

  // Branch B output register
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else if (load_b) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
    end else if (b_ready) begin
      b_valid <= 1'b0;
    end
  end

  // Saturating transfer counters; clear takes priority over a handshake.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_hs && (a_cnt != CNT_MAX)) begin
        a_cnt <= a_cnt + 1'b1;
      end
      if (b_hs && (b_cnt != CNT_MAX)) begin
        b_cnt <= b_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/demux1to2_stream.md
Name: demux1to2_stream

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake; the counterpart of the 2-to-1 select mux used in the carry-select adders.
- Routes each accepted input word to branch A (sel=1) or branch B (sel=0), matching the mux's select convention.
- Feeds operand words to two parallel adder slices.
- Each branch owns a one-entry output register and a saturating transfer counter.

Parameters:
WIDTH, 16, data word width in bits
CNT_W, 8, width of each per-branch transfer counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_data  input  WIDTH  input word
in_valid  input  1  input word valid
sel  input  1  branch select: 1 routes to A, 0 routes to B
in_ready  output  1  block accepts in_data this cycle
a_data  output  WIDTH  branch A word
a_valid  output  1  branch A word valid
a_ready  input  1  branch A consumer ready
b_data  output  WIDTH  branch B word
b_valid  output  1  branch B word valid
b_ready  input  1  branch B consumer ready
cnt_clr  input  1  synchronous clear of both counters
a_cnt  output  CNT_W  branch A completed transfers, saturating
b_cnt  output  CNT_W  branch B completed transfers, saturating

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- Reset values:
  - a_valid=b_valid=0.
  - a_data=b_data=0.
  - a_cnt=b_cnt=0.
  - Toggle flop (optional feature) = 1.
  - in_ready=0 while rst=1.
- Slot free: free_X = !X_valid || X_ready (X = A or B).
- in_ready (combinational, rst=0): sel=1 gives free_A; sel=0 gives free_B. in_ready never depends on in_valid.
- Accept: when in_valid && in_ready, the selected slot loads in_data. X_valid=1 on the next edge. Latency is one cycle.
- Drain: X_valid && X_ready with no load clears X_valid on the next edge.
- Load and drain in the same cycle: the slot stays valid with the new word. One word per cycle per branch is sustained.
- Stall: while X_valid && !X_ready, X_data and X_valid hold stable.
- Branch isolation: the non-selected branch's register is never touched by an accept.
- Routing changes are back-to-back: alternating sel each cycle with both consumers ready gives one word per cycle total.
- Protocol rule: upstream holds in_data and sel stable while in_valid && !in_ready. The block does not latch sel before accept. A changed sel re-evaluates in_ready against the new branch.
- Counters:
  - X_cnt increments on each X_valid && X_ready handshake.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr forces both counters to 0 next edge. cnt_clr wins over a simultaneous handshake.
- Reset mid-operation: in-flight words are discarded, valids drop next edge, counters clear.
- No combinational path from in_valid to any output. Path from X_ready and sel to in_ready only.

Optional Feature:
- Macro DEMUX_ALT_EN.
- Defined: sel is ignored. An internal toggle flop selects the branch: 1 gives A, 0 gives B. Reset value 1, so the first word goes to A. The flop inverts on every accept (in_valid && in_ready). in_ready uses the toggle in place of sel.
- Undefined: routing by sel only, no toggle flop.
- Port list is identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → in_ready=0, a_valid=b_valid=0, counts 0. Release → in_ready=1.
- Single route: sel=1, in_data=0x1234, a_ready=1 → a_valid=1, a_data=0x1234 one cycle later; b_valid stays 0; a_cnt=1 after handshake.
- Backpressure: a_ready=0, send 0xAAAA then 0xBBBB to A → second word stalls (in_ready=0), a_data holds 0xAAAA. Meanwhile sel=0 word 0x5555 is accepted into B. a_ready=1 → 0xAAAA then 0xBBBB in order.
- Full throughput: both ready, sel alternating 1,0,... for 20 words → in_ready=1 throughout, a_cnt=10, b_cnt=10, no bubbles.
- Saturation/clear: 300 handshakes on B with CNT_W=8 → b_cnt=255. cnt_clr together with a handshake → b_cnt=0.
- DEMUX_ALT_EN build: sel held 0, words 1..4 → A gets 1,3 and B gets 2,4. Reset after word 3 → next word goes to A.
